// File: rtl/uart_tx_framer.sv
// Frames FIFO words into UART bytes: optional header, payload in selectable
// order, optional XOR checksum; counts completed frames.
module uart_tx_framer #(
  parameter int          BYTES_PER_WORD = 5,
  parameter int          HEADER_EN      = 1,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5,
  parameter int          CHECKSUM_EN    = 1
) (
  input  logic                          Clock,
  input  logic                          Reset_N,
  input  logic                          Fifo_Empty,
  input  logic [8*BYTES_PER_WORD-1:0]   Fifo_Read_Data,
  output logic                          Fifo_Read_Enable,
  input  logic                          UART_TX_Ready,
  output logic                          UART_TX_Enable,
  output logic [7:0]                    UART_TX_Data,
  input  logic                          Msb_First,
  output logic                          Busy,
  output logic                          Diag_Valid,
  output logic [15:0]                   Frame_Count
);

  // state | meaning
  // IDLE  | waiting for a non-empty FIFO; pop strobe issued on exit
  // POP   | FIFO Q settling
  // LOAD  | capture word and byte order, clear index/checksum
  // SEND  | waiting for Ready, then strobe current byte
  // HOLD  | waiting for Ready to drop (byte taken), then advance
  typedef enum logic [2:0] {IDLE, POP, LOAD, SEND, HOLD} state_t;

  localparam int IDX_W     = 4;
  localparam int FRAME_LEN = BYTES_PER_WORD + HEADER_EN + CHECKSUM_EN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] HDR_OFS  = IDX_W'(HEADER_EN);
  localparam logic [IDX_W-1:0] TOP_POS  = IDX_W'(BYTES_PER_WORD - 1);

  state_t                        state, state_nx;
  logic [8*BYTES_PER_WORD-1:0]   word_reg;
  logic                          msb_reg;
  logic [IDX_W-1:0]              idx;
  logic [7:0]                    csum;
  logic                          started;
  logic                          send_now, adv, done;
  logic                          is_hdr, is_csum;
  logic [IDX_W-1:0]              pay_pos, sel;
  logic [7:0]                    pay_byte, cur_byte;

  assign Busy = (state != IDLE);

  always_comb begin
    is_hdr   = (HEADER_EN != 0) && (idx == '0);
    is_csum  = (CHECKSUM_EN != 0) && (idx == LAST_IDX);
    pay_pos  = idx - HDR_OFS;
    sel      = msb_reg ? (TOP_POS - pay_pos) : pay_pos;
    pay_byte = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (sel == IDX_W'(i)) pay_byte = word_reg[i*8 +: 8];
    end
    if (is_hdr)       cur_byte = HEADER_BYTE;
    else if (is_csum) cur_byte = csum;
    else              cur_byte = pay_byte;
  end

  // Pop is gated until one clean edge out of reset has been seen.
  always_comb begin
    state_nx         = state;
    Fifo_Read_Enable = 1'b0;
    send_now         = 1'b0;
    adv              = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (Reset_N && started && !Fifo_Empty) begin
          Fifo_Read_Enable = 1'b1;
          state_nx         = POP;
        end
      end
      POP:  state_nx = LOAD;
      LOAD: state_nx = SEND;
      SEND: begin
        if (UART_TX_Ready) begin
          send_now = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (!UART_TX_Ready) begin
          adv = 1'b1;
          if (idx == LAST_IDX) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state          <= IDLE;
      started        <= 1'b0;
      word_reg       <= '0;
      msb_reg        <= 1'b0;
      idx            <= '0;
      csum           <= '0;
      UART_TX_Enable <= 1'b0;
      UART_TX_Data   <= '0;
      Diag_Valid     <= 1'b0;
      Frame_Count    <= '0;
    end else begin
      state          <= state_nx;
      started        <= 1'b1;
      UART_TX_Enable <= send_now;
      Diag_Valid     <= done;
      if (state == LOAD) begin
        word_reg <= Fifo_Read_Data;
        msb_reg  <= Msb_First;
        idx      <= '0;
        csum     <= '0;
      end
      if (send_now) begin
        UART_TX_Data <= cur_byte;
        if (!is_hdr && !is_csum) csum <= csum ^ cur_byte;
      end
      if (adv) idx <= done ? '0 : idx + IDX_W'(1);
      if (done) Frame_Count <= Frame_Count + 16'd1;
    end
  end

endmodule
